// File: rtl/dct2d_sequencer.sv
// 8x8 2D DCT sequencer: row pass, transpose, column pass over one shared 1D DCT core.
// Define DCT2D_OUT_ROUND_EN to round output coefficients to integers ((x + 128) >>> 8).
module dct2d_sequencer #(
  parameter int LATENCY = 8,
  parameter int W       = 22
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [8*W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*W-1:0] dct_in,
  input  logic [8*W-1:0] dct_out,
  output logic [8*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW      = 3'd1,
    S_ROW_WAIT = 3'd2,
    S_COL      = 3'd3,
    S_COL_WAIT = 3'd4,
    S_OUT      = 3'd5
  } state_t;

  function automatic logic [W-1:0] conv_coef(input logic [W-1:0] x);
`ifdef DCT2D_OUT_ROUND_EN
    logic signed [W:0] sum_v;
    sum_v = $signed({x[W-1], x}) + $signed((W+1)'(9'd128));
    return W'(sum_v >>> 4'd8);
`else
    return x;
`endif
  endfunction

  state_t         state_q;
  logic [2:0]     cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [8*W-1:0] dct_in_q;
  logic [8*W-1:0] out_data_q;

  // Tag line tracks which pass/index each in-flight core result belongs to.
  logic           tag_vld_q [LATENCY];
  logic           tag_col_q [LATENCY];
  logic [2:0]     tag_idx_q [LATENCY];

  logic [W-1:0]   t_q [8][8];
  logic [W-1:0]   o_q [8][8];

  logic           accept_s;
  logic           exit_vld_s;
  logic           exit_col_s;
  logic [2:0]     exit_idx_s;
  logic           row_done_s;
  logic           col_done_s;
  logic [2:0]     out_sel_s;
  logic [8*W-1:0] col_vec_s;
  logic [8*W-1:0] out_row_s;

  assign accept_s   = in_valid & in_ready_q;
  assign exit_vld_s = tag_vld_q[LATENCY-1];
  assign exit_col_s = tag_col_q[LATENCY-1];
  assign exit_idx_s = tag_idx_q[LATENCY-1];
  assign row_done_s = exit_vld_s & ~exit_col_s & (exit_idx_s == 3'd7);
  assign col_done_s = exit_vld_s & exit_col_s & (exit_idx_s == 3'd7);
  assign out_sel_s  = out_valid_q ? (cnt_q + 3'd1) : cnt_q;

  // Column c of the transposed row results, packed as a core input vector.
  always_comb begin
    col_vec_s = '0;
    for (int i = 0; i < 8; i++) begin
      col_vec_s[W*i +: W] = t_q[cnt_q][i];
    end
  end

  // Output row about to be presented: current row on first load, next row after a handshake.
  always_comb begin
    out_row_s = '0;
    for (int i = 0; i < 8; i++) begin
      out_row_s[W*i +: W] = conv_coef(o_q[out_sel_s][i]);
    end
  end

  // Sequencer FSM, core drive, tag line and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dct_in_q    <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_col_q[i] <= 1'b0;
        tag_idx_q[i] <= 3'd0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      tag_vld_q[0] <= 1'b0;
      tag_col_q[0] <= 1'b0;
      tag_idx_q[0] <= 3'd0;
      dct_in_q     <= '0;

      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_s) begin
            dct_in_q     <= in_data;
            tag_vld_q[0] <= 1'b1;
            tag_idx_q[0] <= 3'd0;
            cnt_q        <= 3'd1;
            busy_q       <= 1'b1;
            state_q      <= S_ROW;
          end
        end
        S_ROW: begin
          if (accept_s) begin
            dct_in_q     <= in_data;
            tag_vld_q[0] <= 1'b1;
            tag_idx_q[0] <= cnt_q;
            if (cnt_q == 3'd7) begin
              in_ready_q <= 1'b0;
              cnt_q      <= 3'd0;
              state_q    <= S_ROW_WAIT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_ROW_WAIT: begin
          if (row_done_s) begin
            state_q <= S_COL;
          end
        end
        S_COL: begin
          dct_in_q     <= col_vec_s;
          tag_vld_q[0] <= 1'b1;
          tag_col_q[0] <= 1'b1;
          tag_idx_q[0] <= cnt_q;
          if (cnt_q == 3'd7) begin
            cnt_q   <= 3'd0;
            state_q <= S_COL_WAIT;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_COL_WAIT: begin
          if (col_done_s) begin
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (!out_valid_q) begin
            out_data_q  <= out_row_s;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            if (cnt_q == 3'd7) begin
              out_valid_q <= 1'b0;
              cnt_q       <= 3'd0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              out_data_q <= out_row_s;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= 3'd0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Row results land transposed in T; column results land in O.
  always_ff @(posedge clk) begin
    if (exit_vld_s) begin
      for (int j = 0; j < 8; j++) begin
        if (exit_col_s) begin
          o_q[j][exit_idx_s] <= dct_out[W*j +: W];
        end else begin
          t_q[j][exit_idx_s] <= dct_out[W*j +: W];
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign dct_in    = dct_in_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dct2d_sequencer.sv
// Self-checking bench for dct2d_sequencer: integer 1D DCT core model, golden 2D model, scoreboard.
module tb_dct2d_sequencer;

  localparam int LATENCY = 8;
  localparam int W       = 22;
  localparam int VW      = 8 * W;
`ifdef DCT2D_OUT_ROUND_EN
  localparam int DC_EXP = 64;
`else
  localparam int DC_EXP = 16384;
`endif

  localparam int CM [8][8] = '{
    '{ 64,  64,  64,  64,  64,  64,  64,  64},
    '{ 63,  53,  36,  12, -12, -36, -53, -63},
    '{ 59,  24, -24, -59, -59, -24,  24,  59},
    '{ 53, -12, -63, -36,  36,  63,  12, -53},
    '{ 45, -45, -45,  45,  45, -45, -45,  45},
    '{ 36, -63,  12,  53, -53, -12,  63, -36},
    '{ 24, -59,  59, -24, -24,  59, -59,  24},
    '{ 12, -36,  53, -63,  63, -53,  36, -12}
  };

  logic          clk;
  logic          reset;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] dct_in;
  logic [VW-1:0] dct_out;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            acc0 = 0;
  int            t_free = 0;
  int            rows_seen = 0;
  int            valid_cnt = 0;
  int            last_rise_cyc = 0;
  logic [VW-1:0] first_row = '0;
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] cur_blk [8];
  logic [VW-1:0] pipe_q [1:15];

  dct2d_sequencer #(.LATENCY(LATENCY), .W(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dct_in(dct_in), .dct_out(dct_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  function automatic logic [VW-1:0] dct1d(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    longint        acc;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        acc = acc + longint'($signed(v[W*i +: W])) * longint'(CM[k][i]);
      end
      r[W*k +: W] = W'(acc >>> 6);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
`ifdef DCT2D_OUT_ROUND_EN
    longint xv;
    xv = longint'($signed(x));
    return W'((xv + 128) >>> 8);
`else
    return x;
`endif
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: result of dct_in is sampled by the DUT LATENCY edges after it was driven.
  always @(posedge clk) begin
    pipe_q[1] <= dct1d(dct_in);
    for (int i = 2; i < 16; i++) pipe_q[i] <= pipe_q[i-1];
  end

  if (LATENCY == 1) begin : g_l1
    assign dct_out = dct1d(dct_in);
  end else begin : g_ln
    assign dct_out = pipe_q[LATENCY-1];
  end

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %b, want %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: got no event, want event within bound", tag);
  endtask

  // Output monitor: scoreboard pop on handshake, hold check during stalls.
  initial begin : monitor
    logic          stall_prev;
    logic          vld_prev;
    logic [VW-1:0] prev_data;
    stall_prev = 1'b0;
    vld_prev   = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
        vld_prev   = 1'b0;
      end else begin
        if (stall_prev) begin
          check_bit("hold_valid", out_valid, 1'b1);
          check_vec("hold_data", out_data, prev_data);
        end
        if (out_valid) begin
          valid_cnt++;
          if (!vld_prev) last_rise_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          if (rows_seen % 8 == 0) first_row = out_data;
          rows_seen++;
          if (exp_q.size() == 0) fail_now("sb_underflow");
          else check_vec("out_row", out_data, exp_q.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        vld_prev   = out_valid;
        prev_data  = out_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic const_block();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) cur_blk[r][W*i +: W] = W'(256);
  endtask

  task automatic rand_block();
    int v;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        v = int'($urandom_range(0, 2000)) - 1000;
        cur_blk[r][W*i +: W] = W'(v);
      end
    end
  endtask

  task automatic push_gold();
    logic [VW-1:0] rr [8];
    logic [VW-1:0] cc [8];
    logic [VW-1:0] colv;
    logic [VW-1:0] orow;
    for (int r = 0; r < 8; r++) rr[r] = dct1d(cur_blk[r]);
    for (int c = 0; c < 8; c++) begin
      colv = '0;
      for (int i = 0; i < 8; i++) colv[W*i +: W] = rr[i][W*c +: W];
      cc[c] = dct1d(colv);
    end
    for (int k = 0; k < 8; k++) begin
      orow = '0;
      for (int c = 0; c < 8; c++) orow[W*c +: W] = conv(cc[c][W*k +: W]);
      exp_q.push_back(orow);
    end
  endtask

  task automatic send_row(input int r);
    bit rdy;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = cur_blk[r];
    for (int i = 0; i < 100; i++) begin
      rdy = in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("row_accept");
    if (r == 0) acc0 = cyc;
  endtask

  task automatic send_block(input int gap_max, input bit hold);
    int g;
    for (int r = 0; r < 8; r++) begin
      if (r > 0 && gap_max > 0) begin
        g = int'($urandom_range(0, gap_max));
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) tick();
        end
      end
      send_row(r);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain");
    out_ready = 1'b1;
    t_free = cyc;
  endtask

  initial begin
    logic [VW-1:0] col0_exp;
    int            v0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_vec("rst_dct_in", dct_in, '0);
    check_vec("rst_out_data", out_data, '0);
    reset = 1'b0;
    tick();
    check_bit("in_ready_rise", in_ready, 1'b1);

    // Constant block, in_valid held high throughout, no backpressure.
    const_block();
    push_gold();
    out_ready = 1'b1;
    send_block(0, 1'b1);
    tick();
    check_vec("rowwait_dct_in", dct_in, '0);
    check_bit("rowwait_in_ready", in_ready, 1'b0);
    wait_until(acc0 + 8 + LATENCY);
    col0_exp = '0;
    for (int i = 0; i < 8; i++) col0_exp[W*i +: W] = W'(2048);
    check_vec("col0_issue", dct_in, col0_exp);
    check_bit("col_in_ready", in_ready, 1'b0);
    wait_until(acc0 + 16 + LATENCY);
    check_vec("colwait_dct_in", dct_in, '0);
    wait_until(acc0 + 18 + 2 * LATENCY);
    check_bit("out_in_ready", in_ready, 1'b0);
    check_bit("out_valid_on", out_valid, 1'b1);
    drain(1'b0);
    in_valid = 1'b0;
    check_int("first_out_cycle", last_rise_cyc - acc0, 16 + 2 * LATENCY);
    check_int("busy_fall", t_free - last_rise_cyc, 8);
    check_bit("idle_in_ready", in_ready, 1'b1);
    check_int("dc_coef", int'($signed(first_row[W-1:0])), DC_EXP);
    check_vec("dc_row_rest", first_row >> W, '0);

    // Back-to-back random block: earliest accept, then gapped rows and backpressure.
    rand_block();
    push_gold();
    send_block(3, 1'b0);
    check_int("next_accept", acc0 - t_free, 1);
    drain(1'b1);
    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(0, 3)) tick();
      rand_block();
      push_gold();
      send_block(3, 1'b0);
      drain(1'b1);
    end

    // Abort a block at cycle 12 with reset, then recover with a fresh constant block.
    const_block();
    send_block(0, 1'b0);
    wait_until(acc0 + 12);
    reset = 1'b1;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_out_valid", out_valid, 1'b0);
    tick();
    reset = 1'b0;
    v0 = valid_cnt;
    repeat (60) tick();
    check_int("abort_no_valid", valid_cnt - v0, 0);
    const_block();
    push_gold();
    send_block(2, 1'b0);
    drain(1'b1);
    check_int("recover_dc_coef", int'($signed(first_row[W-1:0])), DC_EXP);

    check_int("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
